// File: rtl/prog_mem_loader_if.sv
// Host byte channel and program-memory write port of the program loader.
// master: host / bench side (drives start and the byte stream).
// slave : the loader itself.
interface prog_mem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              start;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              pm_we;
    logic [ADDR_W-1:0] pm_addr;
    logic [DATA_W-1:0] pm_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, in_byte, in_valid,
        input  in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, in_byte, in_valid,
        output in_ready, pm_we, pm_addr, pm_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: streams a program image (LEN byte, then hi/lo byte pairs)
// from a host byte channel into program memory and keeps the CPU in reset
// until a complete image has been loaded.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing XOR checksum byte
// (LEN ^ all data bytes) must match, otherwise err is raised and the CPU
// stays held.
module prog_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    prog_mem_loader_if.slave   ldr
);
    localparam int RW = ADDR_W + 1;   // remaining-word count must hold 2^ADDR_W

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_HI,
        S_LO,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_in_ready;
    logic              w_xfer;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_word_cnt;
    logic [RW-1:0]     r_remaining;
    logic              r_pm_we;
    logic [ADDR_W-1:0] r_pm_addr;
    logic [DATA_W-1:0] r_pm_wdata;
    logic              r_cpu_hold;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
    logic              r_err;
`endif

    assign w_xfer = ldr.in_valid & w_in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state decode; the channel is open in every byte-receiving state.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            S_IDLE: if (ldr.start) w_state_next = S_LEN;
            S_LEN: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_state_next = S_HI;
            end
            S_HI: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_state_next = S_LO;
            end
            S_LO: begin
                w_in_ready = 1'b1;
                if (w_xfer) begin
                    if (r_remaining != RW'(1)) w_state_next = S_HI;
`ifdef LOADER_CHECKSUM_EN
                    else                       w_state_next = S_CSUM;
`else
                    else                       w_state_next = S_FIN;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                w_in_ready = 1'b1;
                if (w_xfer) w_state_next = (ldr.in_byte == r_csum) ? S_FIN : S_IDLE;
            end
`endif
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: byte capture, word write strobe, counters, hold/err flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi        <= '0;
            r_word_cnt  <= '0;
            r_remaining <= '0;
            r_pm_we     <= 1'b0;
            r_pm_addr   <= '0;
            r_pm_wdata  <= '0;
            r_cpu_hold  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_pm_we <= 1'b0;
            case (r_state)
                S_IDLE: if (ldr.start) begin
                    r_cpu_hold <= 1'b1;
                    r_word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                    r_err      <= 1'b0;
`endif
                end
                S_LEN: if (w_xfer) begin
                    // A zero length byte means a full 2^ADDR_W-word image.
                    r_remaining <= (ldr.in_byte == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                         : RW'(ldr.in_byte);
`ifdef LOADER_CHECKSUM_EN
                    r_csum      <= ldr.in_byte;
`endif
                end
                S_HI: if (w_xfer) begin
                    r_hi   <= ldr.in_byte;
`ifdef LOADER_CHECKSUM_EN
                    r_csum <= r_csum ^ ldr.in_byte;
`endif
                end
                S_LO: if (w_xfer) begin
                    r_pm_we     <= 1'b1;
                    r_pm_addr   <= r_word_cnt;
                    r_pm_wdata  <= DATA_W'({r_hi, ldr.in_byte});
                    r_word_cnt  <= r_word_cnt + ADDR_W'(1);
                    r_remaining <= r_remaining - RW'(1);
`ifdef LOADER_CHECKSUM_EN
                    r_csum      <= r_csum ^ ldr.in_byte;
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: if (w_xfer && (ldr.in_byte != r_csum)) r_err <= 1'b1;
`endif
                S_FIN:   r_cpu_hold <= 1'b0;
                default: ;
            endcase
        end
    end

    assign ldr.in_ready = w_in_ready;
    assign ldr.pm_we    = r_pm_we;
    assign ldr.pm_addr  = r_pm_addr;
    assign ldr.pm_wdata = r_pm_wdata;
    assign ldr.cpu_hold = r_cpu_hold;
    assign ldr.busy     = (r_state != S_IDLE);
    assign ldr.done     = (r_state == S_FIN);
`ifdef LOADER_CHECKSUM_EN
    assign ldr.err      = r_err;
`else
    assign ldr.err      = 1'b0;
`endif
endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: frames are built as byte queues, the expected
// memory writes are derived from the frame contents, and a monitor compares
// every write strobe / done pulse against that expectation.
module tb_prog_mem_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prog_mem_loader_if ldr ();

    prog_mem_loader dut (
        .clk (clk),
        .rst (rst),
        .ldr (ldr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int ready_waits = 0;
    bit exp_ok = 1'b1;
    logic [7:0]  frame_q[$];
    logic [23:0] exp_q[$];     // {addr, hi, lo}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Checksum byte (or a corrupted one) appended when the feature is built in.
    task automatic append_csum(input bit good);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (frame_q[i]) x ^= frame_q[i];
        if (!good) x ^= 8'($urandom_range(1, 255));
        frame_q.push_back(x);
        exp_ok = good;
`else
        exp_ok = 1'b1;
`endif
    endtask

    task automatic make_frame(input int n, input bit good);
        int words;
        frame_q.delete();
        frame_q.push_back(8'(n));
        words = (n == 0) ? 256 : n;
        for (int i = 0; i < 2 * words; i++) frame_q.push_back(8'($urandom_range(0, 255)));
        append_csum(good);
    endtask

    // Word i of an image is written at address i with data {byte 2i+1, byte 2i+2}.
    task automatic expect_words(input int k);
        for (int i = 0; i < k; i++)
            exp_q.push_back({8'(i), frame_q[1 + 2 * i], frame_q[2 + 2 * i]});
    endtask

    // Drives start then the frame bytes; stops early after 'limit' bytes if limit >= 0.
    task automatic send_frame(input int min_stall, input int max_stall, input int limit);
        int waits;
        done_seen = 0;
        @(negedge clk); ldr.start = 1'b1;
        @(negedge clk); ldr.start = 1'b0;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (limit >= 0 && i == limit) break;
            ldr.in_valid = 1'b0;
            repeat ($urandom_range(max_stall, min_stall)) @(negedge clk);
            ldr.in_valid = 1'b1;
            ldr.in_byte  = frame_q[i];
            waits = 0;
            while (!ldr.in_ready && waits < 100) begin
                @(negedge clk);
                waits++;
                ready_waits++;
            end
            if (waits >= 100) check("ready_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        ldr.in_valid = 1'b0;
    endtask

    task automatic finish_frame();
        int cnt;
        cnt = 0;
        while (ldr.busy && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 1000) check("busy_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        check("writes_left", exp_q.size(), 0);
        check("done_count", done_seen, exp_ok ? 1 : 0);
        check("cpu_hold_end", ldr.cpu_hold, !exp_ok);
        check("err_end", ldr.err, !exp_ok);
        check("busy_end", ldr.busy, 0);
    endtask

    // Monitor: every cycle compares writes and hold/done/err relationships.
    initial begin
        logic        prev_done;
        logic [23:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ldr.pm_we) begin
                if (exp_q.size() == 0) check("extra_write", {8'h0, ldr.pm_addr, ldr.pm_wdata}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    check("pm_addr", ldr.pm_addr, e[23:16]);
                    check("pm_wdata", ldr.pm_wdata, e[15:0]);
                end
            end
            if (ldr.done) begin
                done_seen++;
                check("hold_at_done", ldr.cpu_hold, 1);
            end
            if (prev_done) check("hold_release", ldr.cpu_hold, 0);
            if (ldr.busy) begin
                check("hold_while_busy", ldr.cpu_hold, 1);
                check("err_while_busy", ldr.err, 0);
            end
            if (ldr.in_ready) check("ready_only_busy", ldr.busy, 1);
            prev_done = ldr.done;
        end
    end

    initial begin
        ldr.start = 1'b0; ldr.in_valid = 1'b0; ldr.in_byte = 8'h00;
        rst = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cpu_hold", ldr.cpu_hold, 1);
        check("rst_in_ready", ldr.in_ready, 0);
        check("rst_pm_we", ldr.pm_we, 0);
        check("rst_pm_addr", ldr.pm_addr, 0);
        check("rst_pm_wdata", ldr.pm_wdata, 0);
        check("rst_done", ldr.done, 0);
        check("rst_busy", ldr.busy, 0);
        check("rst_err", ldr.err, 0);
        rst = 1'b0;
        @(negedge clk);

        // N=2 back-to-back; model pinned against hand-computed words
        frame_q = '{8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        append_csum(1'b1);
        expect_words(2);
        check("model_w0", exp_q[0], 24'h00A1B2);
        check("model_w1", exp_q[1], 24'h01C3D4);
        ready_waits = 0;
        send_frame(0, 0, -1);
        check("b2b_no_bubble", ready_waits, 0);
        check("done_after_last", ldr.done, 1);
        finish_frame();

        // Same frame with 3-cycle gaps between bytes
        expect_words(2);
        send_frame(3, 3, -1);
        finish_frame();

        // Full 256-word image, back-to-back
        make_frame(0, 1'b1);
        expect_words(256);
        check("model_last_addr", exp_q[255][23:16], 8'hFF);
        send_frame(0, 0, -1);
        finish_frame();

        // Reset after the third byte of an N=2 frame
        make_frame(2, 1'b1);
        expect_words(1);
        send_frame(0, 1, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_hold", ldr.cpu_hold, 1);
        check("abort_busy", ldr.busy, 0);
        check("abort_ready", ldr.in_ready, 0);
        @(negedge clk);
        check("abort_writes", exp_q.size(), 0);
        check("abort_done", done_seen, 0);
        make_frame(2, 1'b1);
        expect_words(2);
        send_frame(0, 2, -1);
        finish_frame();

`ifdef LOADER_CHECKSUM_EN
        // Fixed checksum frames: good then bad
        frame_q = '{8'h01, 8'h12, 8'h34};
        append_csum(1'b1);
        check("model_csum", frame_q[3], 8'h27);
        expect_words(1);
        send_frame(0, 0, -1);
        finish_frame();
        frame_q = '{8'h01, 8'h12, 8'h34, 8'h00};
        exp_ok = 1'b0;
        expect_words(1);
        send_frame(0, 0, -1);
        finish_frame();
`endif

        // Randomized frames with random stalls (and occasional bad checksums)
        for (int t = 0; t < 10; t++) begin
            int n;
            n = $urandom_range(1, 12);
            make_frame(n, ($urandom_range(0, 3) != 0));
            expect_words(n);
            send_frame(0, 3, -1);
            finish_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
